// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALU op codes, MIPS opcode/funct constants and the decoded-control bundle
// that travels from the instruction decoder into the EX stage.
package alu_pkg;

    localparam logic [3:0] AluAdd     = 4'd0;
    localparam logic [3:0] AluSub     = 4'd1;
    localparam logic [3:0] AluAnd     = 4'd2;
    localparam logic [3:0] AluOr      = 4'd3;
    localparam logic [3:0] AluShftL   = 4'd4;
    localparam logic [3:0] AluShftRL  = 4'd5;
    localparam logic [3:0] AluShftRA  = 4'd6;
    localparam logic [3:0] AluGreater = 4'd7;
    localparam logic [3:0] AluLess    = 4'd8;
    localparam logic [3:0] AluNor     = 4'd9;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpAddiu = 6'h09;
    localparam logic [5:0] OpSlti  = 6'h0A;
    localparam logic [5:0] OpAndi  = 6'h0C;
    localparam logic [5:0] OpOri   = 6'h0D;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    localparam logic [5:0] FnSll  = 6'h00;
    localparam logic [5:0] FnSrl  = 6'h02;
    localparam logic [5:0] FnSra  = 6'h03;
    localparam logic [5:0] FnAdd  = 6'h20;
    localparam logic [5:0] FnAddu = 6'h21;
    localparam logic [5:0] FnSub  = 6'h22;
    localparam logic [5:0] FnSubu = 6'h23;
    localparam logic [5:0] FnAnd  = 6'h24;
    localparam logic [5:0] FnOr   = 6'h25;
    localparam logic [5:0] FnNor  = 6'h27;
    localparam logic [5:0] FnSlt  = 6'h2A;

    typedef struct packed {
        logic [3:0]  alu_ctrl;
        logic [4:0]  shamt;
        logic [31:0] imm;
        logic        use_imm;
        logic        ovf_check;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        illegal;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } dec_ctrl_t;

    // Turn a decoded instruction into a harmless bubble, keeping only the data fields.
    function automatic dec_ctrl_t kill_ctrl(input dec_ctrl_t c);
        dec_ctrl_t k;
        k           = c;
        k.use_imm   = 1'b0;
        k.ovf_check = 1'b0;
        k.reg_write = 1'b0;
        k.mem_read  = 1'b0;
        k.mem_write = 1'b0;
        k.branch    = 1'b0;
        k.jump      = 1'b0;
        k.illegal   = 1'b0;
        return k;
    endfunction

endpackage

// File: rtl/alu_op_decode_comb.sv
// Purely combinational MIPS instruction decoder: 32-bit instruction to decoded-control bundle.
// reads_rt flags instructions whose rt field is a source operand (used by load-use detection).
module alu_op_decode_comb
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    output dec_ctrl_t   ctrl,
    output logic        reads_rt
);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] sign_imm;
    logic [31:0] zero_imm;

    assign opcode   = instr[31:26];
    assign funct    = instr[5:0];
    assign sign_imm = {{16{instr[15]}}, instr[15:0]};
    assign zero_imm = {16'h0000, instr[15:0]};

    always_comb begin
        ctrl          = '0;
        ctrl.alu_ctrl = AluAdd;
        ctrl.rs       = instr[25:21];
        ctrl.rt       = instr[20:16];
        reads_rt      = 1'b0;
        case (opcode)
            OpRtype: begin
                ctrl.rd        = instr[15:11];
                ctrl.reg_write = 1'b1;
                reads_rt       = 1'b1;
                case (funct)
                    FnAdd:  begin ctrl.alu_ctrl = AluAdd; ctrl.ovf_check = 1'b1; end
                    FnAddu: ctrl.alu_ctrl = AluAdd;
                    FnSub:  begin ctrl.alu_ctrl = AluSub; ctrl.ovf_check = 1'b1; end
                    FnSubu: ctrl.alu_ctrl = AluSub;
                    FnAnd:  ctrl.alu_ctrl = AluAnd;
                    FnOr:   ctrl.alu_ctrl = AluOr;
                    FnNor:  ctrl.alu_ctrl = AluNor;
                    FnSlt:  ctrl.alu_ctrl = AluLess;
                    FnSll:  begin ctrl.alu_ctrl = AluShftL;  ctrl.shamt = instr[10:6]; end
                    FnSrl:  begin ctrl.alu_ctrl = AluShftRL; ctrl.shamt = instr[10:6]; end
                    FnSra:  begin ctrl.alu_ctrl = AluShftRA; ctrl.shamt = instr[10:6]; end
                    default: ctrl.illegal = 1'b1;
                endcase
            end
            OpAddi, OpAddiu, OpSlti, OpAndi, OpOri, OpLw: begin
                ctrl.rd        = instr[20:16];
                ctrl.reg_write = 1'b1;
                ctrl.use_imm   = 1'b1;
                ctrl.imm       = sign_imm;
                if (opcode == OpAddi) ctrl.ovf_check = 1'b1;
                if (opcode == OpSlti) ctrl.alu_ctrl = AluLess;
                if (opcode == OpAndi) begin ctrl.alu_ctrl = AluAnd; ctrl.imm = zero_imm; end
                if (opcode == OpOri)  begin ctrl.alu_ctrl = AluOr;  ctrl.imm = zero_imm; end
                if (opcode == OpLw)   ctrl.mem_read = 1'b1;
            end
            OpSw: begin
                ctrl.use_imm   = 1'b1;
                ctrl.imm       = sign_imm;
                ctrl.mem_write = 1'b1;
                reads_rt       = 1'b1;
            end
            OpBeq: begin
                ctrl.alu_ctrl = AluSub;
                ctrl.imm      = sign_imm;
                ctrl.branch   = 1'b1;
                reads_rt      = 1'b1;
            end
            OpJ: ctrl.jump = 1'b1;
            default: ctrl.illegal = 1'b1;
        endcase

        if (ctrl.illegal) begin
            ctrl          = '0;
            ctrl.illegal  = 1'b1;
            ctrl.alu_ctrl = AluAdd;
            ctrl.rs       = instr[25:21];
            ctrl.rt       = instr[20:16];
            reads_rt      = 1'b0;
        end
        // Writes to $zero are architecturally discarded; this also makes the all-zero NOP inert.
        if (ctrl.rd == 5'd0) ctrl.reg_write = 1'b0;
    end

endmodule

// File: rtl/alu_op_decoder.sv
// Registered MIPS decoder / ID-EX pipeline register with stall, flush and optional load-use
// bubble insertion (enabled by defining DECODE_LOAD_USE_EN).
module alu_op_decoder
    import alu_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_instr,
    input  logic        i_valid,
    input  logic        i_stall,
    input  logic        i_flush,
    output logic        o_ready,
    output logic        o_valid,
    output logic [3:0]  o_ALUControl,
    output logic [4:0]  o_shiftAmount,
    output logic [31:0] o_imm,
    output logic        o_useImm,
    output logic        o_ovfCheck,
    output logic        o_regWrite,
    output logic        o_memRead,
    output logic        o_memWrite,
    output logic        o_branch,
    output logic        o_jump,
    output logic [4:0]  o_rs,
    output logic [4:0]  o_rt,
    output logic [4:0]  o_rd,
    output logic        o_illegal
);

    dec_ctrl_t dec;
    dec_ctrl_t ctrl_q;
    logic      valid_q;
    logic      dec_reads_rt;
    logic      hazard;

    alu_op_decode_comb u_decode (
        .instr    (i_instr),
        .ctrl     (dec),
        .reads_rt (dec_reads_rt)
    );

`ifdef DECODE_LOAD_USE_EN
    assign hazard = valid_q && ctrl_q.mem_read && (ctrl_q.rt != 5'd0) && i_valid &&
                    ((dec.rs == ctrl_q.rt) || (dec_reads_rt && (dec.rt == ctrl_q.rt)));
`else
    logic unused_reads_rt;
    assign unused_reads_rt = dec_reads_rt;
    assign hazard          = 1'b0;
`endif

    assign o_ready = !i_stall && !hazard;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
        end else if (i_flush || (!i_stall && hazard)) begin
            valid_q <= 1'b0;
            ctrl_q  <= kill_ctrl(ctrl_q);
        end else if (!i_stall) begin
            valid_q <= i_valid;
            ctrl_q  <= i_valid ? dec : kill_ctrl(dec);
        end
    end

    assign o_valid       = valid_q;
    assign o_ALUControl  = ctrl_q.alu_ctrl;
    assign o_shiftAmount = ctrl_q.shamt;
    assign o_imm         = ctrl_q.imm;
    assign o_useImm      = ctrl_q.use_imm;
    assign o_ovfCheck    = ctrl_q.ovf_check;
    assign o_regWrite    = ctrl_q.reg_write;
    assign o_memRead     = ctrl_q.mem_read;
    assign o_memWrite    = ctrl_q.mem_write;
    assign o_branch      = ctrl_q.branch;
    assign o_jump        = ctrl_q.jump;
    assign o_rs          = ctrl_q.rs;
    assign o_rt          = ctrl_q.rt;
    assign o_rd          = ctrl_q.rd;
    assign o_illegal     = ctrl_q.illegal;

endmodule

// File: tb/tb_alu_op_decoder.sv
// Directed self-checking bench for alu_op_decoder; expectations track DECODE_LOAD_USE_EN.
module tb_alu_op_decoder;

    logic        clk = 1'b0;
    logic        reset, valid, stall, flush;
    logic [31:0] instr;
    logic        ready, o_valid_s, use_imm, ovf, reg_write, mem_read, mem_write;
    logic        branch, jump, illegal;
    logic [3:0]  alu_ctrl;
    logic [4:0]  shamt, rs, rt, rd;
    logic [31:0] imm;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_op_decoder dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_instr       (instr),
        .i_valid       (valid),
        .i_stall       (stall),
        .i_flush       (flush),
        .o_ready       (ready),
        .o_valid       (o_valid_s),
        .o_ALUControl  (alu_ctrl),
        .o_shiftAmount (shamt),
        .o_imm         (imm),
        .o_useImm      (use_imm),
        .o_ovfCheck    (ovf),
        .o_regWrite    (reg_write),
        .o_memRead     (mem_read),
        .o_memWrite    (mem_write),
        .o_branch      (branch),
        .o_jump        (jump),
        .o_rs          (rs),
        .o_rt          (rt),
        .o_rd          (rd),
        .o_illegal     (illegal)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cap(input logic [31:0] ins);
        instr = ins;
        valid = 1'b1;
        #1;
        check("ready_on_capture", ready, 1);
        tick();
    endtask

    initial begin
        reset = 1'b1; valid = 1'b0; stall = 1'b0; flush = 1'b0; instr = 32'h0;
        tick(); tick();
        reset = 1'b0;
        check("rst_valid", o_valid_s, 0);
        check("rst_alu", alu_ctrl, 0);
        check("rst_rd", rd, 0);
        check("rst_regwrite", reg_write, 0);
        check("rst_imm", imm, 0);

        cap(32'h00221820);  // add $3,$1,$2
        check("add_valid", o_valid_s, 1);
        check("add_alu", alu_ctrl, 0);
        check("add_rd", rd, 3);
        check("add_rs", rs, 1);
        check("add_rt", rt, 2);
        check("add_regwrite", reg_write, 1);
        check("add_ovf", ovf, 1);
        check("add_useimm", use_imm, 0);

        cap(32'h3405FFFF);  // ori $5,$0,0xFFFF
        check("ori_alu", alu_ctrl, 3);
        check("ori_imm", imm, 32'h0000FFFF);
        check("ori_useimm", use_imm, 1);
        check("ori_rd", rd, 5);
        check("ori_ovf", ovf, 0);

        cap(32'h2005FFFF);  // addi $5,$0,-1
        check("addi_imm", imm, 32'hFFFFFFFF);
        check("addi_ovf", ovf, 1);
        check("addi_regwrite", reg_write, 1);

        cap(32'h00000000);  // nop
        check("nop_valid", o_valid_s, 1);
        check("nop_regwrite", reg_write, 0);
        check("nop_alu", alu_ctrl, 4);

        cap(32'h000311C3);  // sra $2,$3,7
        check("sra_alu", alu_ctrl, 6);
        check("sra_shamt", shamt, 7);
        check("sra_rd", rd, 2);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            instr = 32'h3405FFFF + i;
            #1;
            check("stall_ready", ready, 0);
            tick();
            check("stall_alu", alu_ctrl, 6);
            check("stall_shamt", shamt, 7);
            check("stall_valid", o_valid_s, 1);
        end
        flush = 1'b1;
        tick();
        check("flush_valid", o_valid_s, 0);
        check("flush_regwrite", reg_write, 0);
        stall = 1'b0; flush = 1'b0;

        cap(32'h8C240000);  // lw $4,0($1)
        check("lw_memread", mem_read, 1);
        check("lw_regwrite", reg_write, 1);
        check("lw_rd", rd, 4);
        check("lw_useimm", use_imm, 1);
        instr = 32'h00823020;  // add $6,$4,$2
        #1;
`ifdef DECODE_LOAD_USE_EN
        check("hazard_ready", ready, 0);
        tick();
        check("bubble_valid", o_valid_s, 0);
        check("bubble_memread", mem_read, 0);
        check("bubble_regwrite", reg_write, 0);
        check("after_bubble_ready", ready, 1);
        tick();
`else
        check("nohazard_ready", ready, 1);
        tick();
`endif
        check("use_valid", o_valid_s, 1);
        check("use_rd", rd, 6);
        check("use_rs", rs, 4);

        cap(32'hFC000000);  // opcode 0x3F
        check("ill_illegal", illegal, 1);
        check("ill_valid", o_valid_s, 1);
        check("ill_regwrite", reg_write, 0);
        check("ill_memread", mem_read, 0);
        check("ill_memwrite", mem_write, 0);
        check("ill_alu", alu_ctrl, 0);

        cap(32'hAC220004);  // sw $2,4($1)
        check("sw_memwrite", mem_write, 1);
        check("sw_regwrite", reg_write, 0);
        check("sw_imm", imm, 4);

        cap(32'h1022FFFD);  // beq $1,$2,-3
        check("beq_branch", branch, 1);
        check("beq_alu", alu_ctrl, 1);
        check("beq_useimm", use_imm, 0);
        check("beq_imm", imm, 32'hFFFFFFFD);

        cap(32'h08000010);  // j
        check("j_jump", jump, 1);
        check("j_regwrite", reg_write, 0);

        instr = 32'h00221820;
        valid = 1'b0;
        tick();
        check("novalid_valid", o_valid_s, 0);
        check("novalid_regwrite", reg_write, 0);

        cap(32'h00221820);
        stall = 1'b1;
        reset = 1'b1;
        tick();
        check("midrst_valid", o_valid_s, 0);
        check("midrst_rd", rd, 0);
        check("midrst_regwrite", reg_write, 0);
        check("midrst_ovf", ovf, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
